ld_cell_cond: RTL and testbench
===============================

# ld_cell_cond

Load-cell conditioning stage directly upstream of the steering-enable state machine. It filters the left/right platform load-cell readings with a 4-sample boxcar average and derives the four registered weight/balance flags (sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16). It also provides the 1.3 s rider-settle timer (tmr_full), which the state machine clears via clr_tmr. All outputs connect one-to-one to the same-named state-machine inputs.

## Interface
- MIN_RIDER_WT, default 13'h0200: minimum rider weight, in summed averaged load-cell counts.
- WT_HYST, default 13'h0040: hysteresis half-band around MIN_RIDER_WT. Must satisfy WT_HYST <= MIN_RIDER_WT.
- FAST_SIM, default 0: when 1, timer terminal count is 15'h7FFF instead of 65,000,000.
- clk  in  1  system clock, 50 MHz; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- lft_ld  in  12  left load-cell reading, unsigned, qualified by ld_vld.
- rght_ld  in  12  right load-cell reading, unsigned, qualified by ld_vld.
- ld_vld  in  1  one-cycle strobe: lft_ld/rght_ld hold a new conversion.
- clr_tmr  in  1  synchronous timer clear from the steering-enable SM.
- sum_gt_min  out  1  averaged sum > MIN_RIDER_WT + WT_HYST.
- sum_lt_min  out  1  averaged sum < MIN_RIDER_WT - WT_HYST.
- diff_gt_eigth  out  1  |lft_avg - rght_avg| > sum/8.
- diff_gt_15_16  out  1  |lft_avg - rght_avg| > sum - sum/16.
- tmr_full  out  1  settle timer reached terminal count.
- ld_sum  out  13  registered averaged sum, for telemetry/debug.

## Operation
- History: two 4-deep shift registers of 12-bit samples (lft_hist[0..3], rght_hist[0..3]). On ld_vld, the new sample enters [0] and the older samples shift. Without ld_vld, the history holds. Reset clears all entries to 0.
- Average: lft_avg = (sum of 4 lft entries, 14-bit)[13:2]; same for right. Truncate; no rounding. After reset the history is zero-filled, so the first sample contributes sample/4.
- sum = lft_avg + rght_avg, 13-bit unsigned, no overflow possible.
- diff = |lft_avg - rght_avg|, 12-bit unsigned, computed via a 13-bit signed subtract.
- Thresholds, all 13-bit unsigned compares:
  - gt_thr = MIN_RIDER_WT + WT_HYST
  - lt_thr = MIN_RIDER_WT - WT_HYST
  - eighth = sum >> 3
  - f1516 = sum - (sum >> 4)
- All comparisons are strict. Equality gives 0.
- Flags and ld_sum are registered every cycle from the current averages; they do not wait for ld_vld.
- sum_gt_min and sum_lt_min are never both 1. Inside the hysteresis band both are 0.
- Timer: 26-bit counter (15-bit used when FAST_SIM=1).
  - Counter priority: rst > clr_tmr > increment.
  - Terminal count TC = 26'h3DFD240 (65,000,000 cycles = 1.3 s), or 15'h7FFF when FAST_SIM=1.
  - Counter saturates at TC; it holds until clr_tmr or rst.
  - tmr_full = (count == TC), decoded combinationally from the counter register.

## Timing
- Reset values:
  - history and counter: 0
  - sum_gt_min, diff_gt_eigth, diff_gt_15_16, tmr_full: 0
  - ld_sum: 0
  - sum_lt_min: 1 (empty platform)
- Latency: ld_vld sampled at edge N updates the history at N. Flags and ld_sum reflect it at edge N+1 (2-edge latency from sample to flag).
- Back-to-back ld_vld on consecutive cycles: every sample is accepted. The flags track with 1-cycle lag.
- clr_tmr asserted at edge N: count = 0 after N and tmr_full = 0 in the following cycle. Counting resumes at N+1, and TC is reached at edge N+TC.
- clr_tmr held high: count stays 0.
- clr_tmr in the same cycle as saturation: the clear wins.
- rst mid-operation: all state returns to reset values at that edge, regardless of ld_vld/clr_tmr. The history is zero-filled afterwards.

## Test plan
- Reset then idle: rst high 2 cycles, then 3 cycles with no ld_vld. Required: sum_lt_min=1, all other flags 0, ld_sum=0, tmr_full=0.
- Averaging: after reset, one ld_vld with lft_ld=12'h400, rght_ld=0. Required: ld_sum=13'h100 two edges later. After 3 more identical samples: ld_sum=13'h400, diff_gt_15_16=1 (1024 > 960).
- Rider on, balanced: 4 samples of lft_ld=rght_ld=12'h150 (sum 0x2A0). Required: sum_gt_min=1, sum_lt_min=0, diff_gt_eigth=0, diff_gt_15_16=0.
- Unbalanced and step-off: 4 samples of lft_ld=12'h200, rght_ld=12'h0A0 (sum 672, diff 352). Required: diff_gt_eigth=1, diff_gt_15_16=0. Then 4 samples of lft_ld=12'h2A0, rght_ld=0. Required: diff_gt_15_16=1.
- Hysteresis band: 4 samples of lft_ld=rght_ld=12'h100 (sum 0x200). Required: sum_gt_min=0 and sum_lt_min=0. Sum exactly 0x240 gives sum_gt_min=0; 0x242 gives 1.
- Timer (FAST_SIM=1):
  - clr_tmr pulse at edge N: tmr_full=0 through N+32766 and 1 from N+32767; it stays 1 for 100 extra cycles.
  - clr_tmr again: tmr_full=0 the next cycle.
  - rst asserted while the count is mid-range: count=0.

Source files
------------

// File: rtl/ld_cell_cond.sv
// Load-cell conditioning: 4-sample boxcar average of left/right readings, registered
// weight/balance flags, and the rider-settle timer feeding the steering-enable SM.
module ld_cell_cond #(
    parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
    parameter logic [12:0] WT_HYST      = 13'h0040,
    parameter bit          FAST_SIM     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    input  logic        clr_tmr,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_eigth,
    output logic        diff_gt_15_16,
    output logic        tmr_full,
    output logic [12:0] ld_sum
);

    localparam logic [12:0] GT_THR = MIN_RIDER_WT + WT_HYST;
    localparam logic [12:0] LT_THR = MIN_RIDER_WT - WT_HYST;
    localparam logic [25:0] TC     = FAST_SIM ? 26'h0007FFF : 26'h3DFD240;

    logic [11:0] lft_hist_q  [4];
    logic [11:0] rght_hist_q [4];

    logic [13:0]        lft_tot, rght_tot;
    logic [11:0]        lft_avg, rght_avg;
    logic [12:0]        sum_d;
    logic signed [12:0] diff_s, diff_neg;
    logic [11:0]        diff_d;
    logic [12:0]        eighth, f1516;

    logic        sum_gt_min_q, sum_lt_min_q, diff_gt_eigth_q, diff_gt_15_16_q;
    logic [12:0] ld_sum_q;
    logic [25:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                lft_hist_q[i]  <= '0;
                rght_hist_q[i] <= '0;
            end
        end else if (ld_vld) begin
            lft_hist_q[0]  <= lft_ld;
            rght_hist_q[0] <= rght_ld;
            for (int i = 1; i < 4; i++) begin
                lft_hist_q[i]  <= lft_hist_q[i-1];
                rght_hist_q[i] <= rght_hist_q[i-1];
            end
        end
    end

    always_comb begin
        lft_tot  = {2'b00, lft_hist_q[0]} + {2'b00, lft_hist_q[1]}
                 + {2'b00, lft_hist_q[2]} + {2'b00, lft_hist_q[3]};
        rght_tot = {2'b00, rght_hist_q[0]} + {2'b00, rght_hist_q[1]}
                 + {2'b00, rght_hist_q[2]} + {2'b00, rght_hist_q[3]};
        lft_avg  = lft_tot[13:2];
        rght_avg = rght_tot[13:2];
        sum_d    = {1'b0, lft_avg} + {1'b0, rght_avg};
        diff_s   = $signed({1'b0, lft_avg}) - $signed({1'b0, rght_avg});
        diff_neg = -diff_s;
        diff_d   = diff_s[12] ? diff_neg[11:0] : diff_s[11:0];
        eighth   = sum_d >> 3;
        f1516    = sum_d - (sum_d >> 4);
    end

    // Flags track the live averages every cycle, not just on ld_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_gt_min_q    <= 1'b0;
            sum_lt_min_q    <= 1'b1;
            diff_gt_eigth_q <= 1'b0;
            diff_gt_15_16_q <= 1'b0;
            ld_sum_q        <= '0;
        end else begin
            sum_gt_min_q    <= sum_d > GT_THR;
            sum_lt_min_q    <= sum_d < LT_THR;
            diff_gt_eigth_q <= {1'b0, diff_d} > eighth;
            diff_gt_15_16_q <= {1'b0, diff_d} > f1516;
            ld_sum_q        <= sum_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_tmr)
            cnt_d = '0;
        else if (cnt_q != TC)
            cnt_d = cnt_q + 26'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tmr_full      = (cnt_q == TC);
    assign sum_gt_min    = sum_gt_min_q;
    assign sum_lt_min    = sum_lt_min_q;
    assign diff_gt_eigth = diff_gt_eigth_q;
    assign diff_gt_15_16 = diff_gt_15_16_q;
    assign ld_sum        = ld_sum_q;

endmodule

// File: tb/tb_ld_cell_cond.sv
// Self-checking bench for ld_cell_cond: scoreboarded flag/sum expectations plus
// fixed-value checks and settle-timer timing with FAST_SIM=1.
module tb_ld_cell_cond;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] lft_ld = '0, rght_ld = '0;
    logic        ld_vld = 1'b0, clr_tmr = 1'b0;
    logic        sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, tmr_full;
    logic [12:0] ld_sum;

    ld_cell_cond #(.MIN_RIDER_WT(13'h0200), .WT_HYST(13'h0040), .FAST_SIM(1'b1)) dut (
        .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld),
        .clr_tmr(clr_tmr), .sum_gt_min(sum_gt_min), .sum_lt_min(sum_lt_min),
        .diff_gt_eigth(diff_gt_eigth), .diff_gt_15_16(diff_gt_15_16),
        .tmr_full(tmr_full), .ld_sum(ld_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [16:0] v;   // {gt, lt, d8, d1516, ld_sum}
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;
    logic [11:0] mh_l [4];
    logic [11:0] mh_r [4];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [16:0] model();
        int l, r, s, d;
        logic gt, lt, d8, d1516;
        l  = (int'(mh_l[0]) + int'(mh_l[1]) + int'(mh_l[2]) + int'(mh_l[3])) / 4;
        r  = (int'(mh_r[0]) + int'(mh_r[1]) + int'(mh_r[2]) + int'(mh_r[3])) / 4;
        s  = l + r;
        d  = (l > r) ? l - r : r - l;
        gt = s > (32'h200 + 32'h40);
        lt = s < (32'h200 - 32'h40);
        d8 = d > (s / 8);
        d1516 = d > (s - s / 16);
        return {gt, lt, d8, d1516, 13'(s)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mh_l[i] = '0;
            mh_r[i] = '0;
        end
    endtask

    // Drive one sample for one edge; expected outputs are due one edge later.
    task automatic drive_sample(input logic [11:0] l, input logic [11:0] r);
        exp_t e;
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        step();
        ld_vld = 1'b0;
        for (int i = 3; i > 0; i--) begin
            mh_l[i] = mh_l[i-1];
            mh_r[i] = mh_r[i-1];
        end
        mh_l[0] = l;
        mh_r[0] = r;
        e.due = cyc + 1;
        e.v   = model();
        sb.push_back(e);
    endtask

    task automatic send_and_check(input string name, input logic [11:0] l, input logic [11:0] r);
        exp_t e;
        logic [16:0] got;
        drive_sample(l, r);
        step();
        e   = sb.pop_front();
        got = {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, ld_sum};
        n_chk++;
        if (e.due != cyc || got !== e.v)
            $display("FAIL %s: got %h expected %h (cyc %0d due %0d)", name, got, e.v, cyc, e.due);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) step();
        n_chk++;
        if ({sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16} !== 4'b0100)
            $display("FAIL reset_flags: got %b expected 0100",
                     {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16});
        else n_pass++;
        n_chk++;
        if (ld_sum !== 13'h0) $display("FAIL reset_ld_sum: got %h expected 0", ld_sum);
        else n_pass++;
        n_chk++;
        if (tmr_full !== 1'b0) $display("FAIL reset_tmr_full: got %b expected 0", tmr_full);
        else n_pass++;
    endtask

    task automatic test_averaging();
        // Output must not move on the capture edge itself, only one edge later.
        drive_sample(12'h400, 12'h000);
        n_chk++;
        if (ld_sum !== 13'h0) $display("FAIL avg_latency: got %h expected 0", ld_sum);
        else n_pass++;
        step();
        void'(sb.pop_front());
        n_chk++;
        if (ld_sum !== 13'h100) $display("FAIL avg_first: got %h expected 100", ld_sum);
        else n_pass++;
        for (int i = 0; i < 3; i++) send_and_check("avg_fill", 12'h400, 12'h000);
        n_chk++;
        if (ld_sum !== 13'h400 || diff_gt_15_16 !== 1'b1)
            $display("FAIL avg_full: got sum %h d1516 %b expected 400 1", ld_sum, diff_gt_15_16);
        else n_pass++;
    endtask

    task automatic test_balanced();
        for (int i = 0; i < 4; i++) send_and_check("balanced", 12'h150, 12'h150);
        n_chk++;
        if ({sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16} !== 4'b1000 || ld_sum !== 13'h2A0)
            $display("FAIL balanced_final: got %b sum %h expected 1000 2a0",
                     {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16}, ld_sum);
        else n_pass++;
    endtask

    task automatic test_unbalanced();
        for (int i = 0; i < 4; i++) send_and_check("unbal", 12'h200, 12'h0A0);
        n_chk++;
        if (diff_gt_eigth !== 1'b1 || diff_gt_15_16 !== 1'b0)
            $display("FAIL unbal_final: got d8 %b d1516 %b expected 1 0", diff_gt_eigth, diff_gt_15_16);
        else n_pass++;
        for (int i = 0; i < 4; i++) send_and_check("stepoff", 12'h2A0, 12'h000);
        n_chk++;
        if (diff_gt_15_16 !== 1'b1)
            $display("FAIL stepoff_final: got d1516 %b expected 1", diff_gt_15_16);
        else n_pass++;
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) send_and_check("hyst_mid", 12'h100, 12'h100);
        n_chk++;
        if (sum_gt_min !== 1'b0 || sum_lt_min !== 1'b0)
            $display("FAIL hyst_mid_final: got gt %b lt %b expected 0 0", sum_gt_min, sum_lt_min);
        else n_pass++;
        for (int i = 0; i < 4; i++) send_and_check("hyst_eq", 12'h120, 12'h120);
        n_chk++;
        if (ld_sum !== 13'h240 || sum_gt_min !== 1'b0)
            $display("FAIL hyst_eq_final: got sum %h gt %b expected 240 0", ld_sum, sum_gt_min);
        else n_pass++;
        for (int i = 0; i < 4; i++) send_and_check("hyst_above", 12'h121, 12'h121);
        n_chk++;
        if (ld_sum !== 13'h242 || sum_gt_min !== 1'b1)
            $display("FAIL hyst_above_final: got sum %h gt %b expected 242 1", ld_sum, sum_gt_min);
        else n_pass++;
        for (int i = 0; i < 4; i++) send_and_check("hyst_low", 12'h0DF, 12'h0E0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [16:0] got;
        int errs = 0, seen = 0;
        for (int i = 0; i < 24; i++) begin
            drive_sample(12'($urandom_range(0, 12'hFFF)), 12'($urandom_range(0, 12'h3FF)));
            ld_vld = 1'b1;  // keep strobe high for the next iteration's edge
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e   = sb.pop_front();
                got = {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, ld_sum};
                seen++;
                if (got !== e.v) begin
                    errs++;
                    $display("FAIL b2b: got %h expected %h at cyc %0d", got, e.v, cyc);
                end
            end
        end
        ld_vld = 1'b0;
        step();
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, ld_sum};
            seen++;
            if (e.due != cyc || got !== e.v) begin
                errs++;
                $display("FAIL b2b_tail: got %h expected %h due %0d cyc %0d", got, e.v, e.due, cyc);
            end
        end
        n_chk++;
        if (errs != 0 || seen != 24)
            $display("FAIL b2b_summary: got %0d errors over %0d results expected 0 over 24", errs, seen);
        else n_pass++;
    endtask

    task automatic test_timer();
        int first_one;
        logic early;
        clr_tmr = 1'b1;
        step();                     // edge N
        clr_tmr = 1'b0;
        early = tmr_full;
        first_one = -1;
        for (int k = 1; k <= 32767 + 100; k++) begin
            step();
            if (k <= 32766 && tmr_full !== 1'b0) early = 1'b1;
            if (k >= 32767 && tmr_full !== 1'b1 && first_one == -1) first_one = k;
        end
        n_chk++;
        if (early !== 1'b0) $display("FAIL tmr_early: got early high expected low through N+32766");
        else n_pass++;
        n_chk++;
        if (first_one != -1) $display("FAIL tmr_hold: got low at N+%0d expected 1 from N+32767", first_one);
        else n_pass++;
        clr_tmr = 1'b1;
        step();
        n_chk++;
        if (tmr_full !== 1'b0) $display("FAIL tmr_clr: got %b expected 0", tmr_full);
        else n_pass++;
        for (int k = 0; k < 5; k++) step();
        clr_tmr = 1'b0;
        n_chk++;
        if (tmr_full !== 1'b0) $display("FAIL tmr_clr_held: got %b expected 0", tmr_full);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hit;
        drive_sample(12'h300, 12'h300);
        void'(sb.pop_front());
        for (int k = 0; k < 1000; k++) step();
        rst = 1'b1;
        ld_vld = 1'b1;
        clr_tmr = 1'b0;
        step();
        rst = 1'b0;
        ld_vld = 1'b0;
        model_clear();
        step();
        n_chk++;
        if (sum_lt_min !== 1'b1 || ld_sum !== 13'h0 || sum_gt_min !== 1'b0)
            $display("FAIL rst_mid_flags: got lt %b gt %b sum %h expected 1 0 0", sum_lt_min, sum_gt_min, ld_sum);
        else n_pass++;
        // count was 0 after the rst edge, so TC lands 32767 edges after it
        hit = -1;
        for (int k = 2; k <= 32768; k++) begin
            step();
            if (tmr_full === 1'b1 && hit == -1) hit = k;
        end
        n_chk++;
        if (hit != 32767) $display("FAIL rst_mid_count: got tmr_full first at %0d expected 32767", hit);
        else n_pass++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_averaging();
        test_balanced();
        test_unbalanced();
        test_hysteresis();
        test_back_to_back();
        test_timer();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
